mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 22 ++
 rtl/mem_responder.sv | 98 +++++++++
 tb/tb_mem_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between the multicycle control unit and the memory responder.
interface mem_responder_if;
  logic        Req;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        Ready;
  logic        Busy;
  logic        Fault;
  logic        FaultCause;

  modport master (
    output Req, MemWrite, Addr, WrData,
    input  RdData, Ready, Busy, Fault, FaultCause
  );

  modport slave (
    input  Req, MemWrite, Addr, WrData,
    output RdData, Ready, Busy, Fault, FaultCause
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory with programmable wait states, alignment/range checking
// and a one-cycle Ready pulse per accepted request.
module mem_responder #(
  parameter int WAIT_STATES = 1,
  parameter int DEPTH_WORDS = 256
) (
  input  logic            clk,
  input  logic            Reset,
  mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t      state;
  state_t      stateNext;
  logic [3:0]  cnt;
  logic [31:0] reqAddr;
  logic [31:0] reqWrData;
  logic        reqWrite;
  logic [31:0] rdData;
  logic        faultQ;
  logic        causeQ;
  logic [31:0] mem [DEPTH_WORDS];

  // Returns {fault, cause}; misalignment wins over out-of-range.
  function automatic logic [1:0] classify(input logic [31:0] a);
    logic misaligned;
    logic outOfRange;
    misaligned = |a[1:0];
    outOfRange = ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
    return {misaligned | outOfRange, ~misaligned & outOfRange};
  endfunction

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (bus.Req) stateNext = (WAIT_STATES > 0) ? WAIT : ACCESS;
      WAIT:    if (cnt <= 4'd1) stateNext = ACCESS;
      ACCESS:  stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      cnt       <= '0;
      reqAddr   <= '0;
      reqWrData <= '0;
      reqWrite  <= 1'b0;
      rdData    <= '0;
      faultQ    <= 1'b0;
      causeQ    <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.Req) begin
            reqAddr   <= bus.Addr;
            reqWrData <= bus.WrData;
            reqWrite  <= bus.MemWrite;
            cnt       <= 4'(WAIT_STATES);
          end
        end
        WAIT: cnt <= cnt - 4'd1;
        ACCESS: begin
          {faultQ, causeQ} <= classify(reqAddr);
          rdData           <= '0;
          if (!classify(reqAddr)[1]) begin
            if (reqWrite) mem[reqAddr[AW+1:2]] <= reqWrData;
            else          rdData <= mem[reqAddr[AW+1:2]];
          end
        end
        RESP: begin
          rdData <= '0;
          faultQ <= 1'b0;
          causeQ <= 1'b0;
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Status decodes from the state register so reset clears them without a clock.
  assign bus.Ready      = (state == RESP);
  assign bus.Busy       = (state != IDLE);
  assign bus.Fault      = faultQ;
  assign bus.FaultCause = causeQ;
  assign bus.RdData     = rdData;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder against a word-array reference model.
module tb_mem_responder;

  localparam int WS1   = 1;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  mem_responder_if bus1 ();
  mem_responder_if bus0 ();

  mem_responder #(.WAIT_STATES(WS1), .DEPTH_WORDS(DEPTH)) dut1 (
    .clk(clk), .Reset(Reset), .bus(bus1.slave)
  );
  mem_responder #(.WAIT_STATES(0), .DEPTH_WORDS(DEPTH)) dut0 (
    .clk(clk), .Reset(Reset), .bus(bus0.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] refMem [DEPTH];

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
  endtask

  task automatic checkQuiet1(input string tag);
    checkEq({tag, ".ready"}, 32'(bus1.Ready), 0);
    checkEq({tag, ".busy"}, 32'(bus1.Busy), 0);
    checkEq({tag, ".fault"}, 32'(bus1.Fault), 0);
    checkEq({tag, ".cause"}, 32'(bus1.FaultCause), 0);
    checkEq({tag, ".rdata"}, bus1.RdData, 0);
  endtask

  // One full transaction on the WAIT_STATES=1 instance; optional stray Req while busy.
  task automatic doAccess(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit poke);
    int lat;
    bit mis, oor;
    logic [31:0] expRd;
    mis   = (a % 4) != 0;
    oor   = (a / 4) >= DEPTH;
    expRd = (!wr && !mis && !oor) ? refMem[a / 4] : 32'h0;
    @(negedge clk);
    bus1.Req = 1'b1; bus1.MemWrite = wr; bus1.Addr = a; bus1.WrData = d;
    @(negedge clk);
    bus1.Req = poke; bus1.Addr = a ^ 32'h4; bus1.WrData = ~d; bus1.MemWrite = ~wr;
    lat = 1;
    while (bus1.Ready !== 1'b1 && lat < 20) begin
      checkEq("busyHeld", 32'(bus1.Busy), 1);
      checkEq("noFaultEarly", 32'(bus1.Fault), 0);
      @(negedge clk);
      bus1.Req = 1'b0;
      lat++;
    end
    checkEq("latency", lat, WS1 + 2);
    checkEq("busyResp", 32'(bus1.Busy), 1);
    checkEq("fault", 32'(bus1.Fault), 32'(mis | oor));
    checkEq("cause", 32'(bus1.FaultCause), 32'(!mis && oor));
    checkEq("rdata", bus1.RdData, expRd);
    if (wr && !mis && !oor) refMem[a / 4] = d;
    @(negedge clk);
    checkQuiet1("afterResp");
    @(negedge clk);
    checkEq("singleReady", 32'(bus1.Ready), 0);
  endtask

  initial begin
    int cyc, prev, busyLow, seen, r;
    bit wr;
    logic [31:0] a;

    bus1.Req = 0; bus1.MemWrite = 0; bus1.Addr = 0; bus1.WrData = 0;
    bus0.Req = 0; bus0.MemWrite = 0; bus0.Addr = 0; bus0.WrData = 0;
    clearModel();
    Reset = 1'b1;
    #1 Reset = 1'b0;
    #1;
    checkQuiet1("reset");
    checkEq("reset0.busy", 32'(bus0.Busy), 0);
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b1;

    doAccess(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    doAccess(1'b0, 32'h10, 32'h0, 1'b0);
    doAccess(1'b0, 32'h13, 32'h0, 1'b0);
    doAccess(1'b0, 32'h10, 32'h0, 1'b0);
    doAccess(1'b1, 32'h400, 32'h12345678, 1'b0);
    doAccess(1'b0, 32'h0, 32'h0, 1'b0);
    doAccess(1'b1, 32'h3FC, 32'hA5A5F00D, 1'b0);
    doAccess(1'b0, 32'h3FC, 32'h0, 1'b0);
    doAccess(1'b1, 32'h402, 32'h1, 1'b0);
    doAccess(1'b0, 32'h10, 32'h0, 1'b1);

    // Reset in the middle of a Ready cycle carrying non-zero data.
    @(negedge clk);
    bus1.Req = 1'b1; bus1.MemWrite = 1'b0; bus1.Addr = 32'h10;
    @(negedge clk);
    bus1.Req = 1'b0;
    cyc = 0;
    while (bus1.Ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    checkEq("preResetData", bus1.RdData, 32'hDEADBEEF);
    #2 Reset = 1'b0;
    #1 checkQuiet1("resetResp");
    clearModel();
    @(negedge clk);
    Reset = 1'b1;

    // Reset while a write to 0x20 waits.
    @(negedge clk);
    bus1.Req = 1'b1; bus1.MemWrite = 1'b1; bus1.Addr = 32'h20; bus1.WrData = 32'hCAFEF00D;
    @(negedge clk);
    bus1.Req = 1'b0;
    checkEq("inWait.busy", 32'(bus1.Busy), 1);
    #2 Reset = 1'b0;
    #1 checkQuiet1("resetWait");
    @(negedge clk);
    Reset = 1'b1;
    doAccess(1'b0, 32'h20, 32'h0, 1'b0);
    doAccess(1'b0, 32'h10, 32'h0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      wr = $urandom_range(0, 1);
      if (r < 7)       a = 32'($urandom_range(0, 15)) * 4;
      else if (r == 7) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
      else             a = ($urandom | 32'h400) & 32'hFFFF_FFFC;
      doAccess(wr, a, $urandom, i % 5 == 0);
    end

    // Zero-wait instance with Req held high: three back-to-back reads.
    @(negedge clk);
    bus0.MemWrite = 1'b0; bus0.Addr = 32'h8; bus0.Req = 1'b1;
    cyc = 0; prev = 0; busyLow = 0; seen = 0;
    while (seen < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus0.Ready === 1'b1) begin
        seen++;
        checkEq("ws0.rdata", bus0.RdData, 0);
        checkEq("ws0.fault", 32'(bus0.Fault), 0);
        if (seen == 1) checkEq("ws0.firstLat", cyc, 2);
        else begin
          checkEq("ws0.period", cyc - prev, 3);
          checkEq("ws0.busyLow", busyLow, 1);
        end
        prev = cyc;
        busyLow = 0;
      end else if (bus0.Busy !== 1'b1) busyLow++;
    end
    checkEq("ws0.count", seen, 3);
    bus0.Req = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
